// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between an instruction fetch
// requester and a data requester, with data priority bounded by starvation.
//
// Ports
//   CLK, nRST                 clock, asynchronous active-low reset
//   iREN, iaddr               instruction fetch request and address
//   dREN, dWEN, daddr, dstore data read/write request, address, write data
//   iwait, dwait              requester stalls
//   iload, dload              read data, zero while the matching wait is high
//   ramREN, ramWEN, ramaddr,
//   ramstore                  RAM strobes, address and write data
//   ramload, ramstate         RAM read data and status
//                             (FREE=0, BUSY=1, ACCESS=2, ERROR=3)
//   err                       sticky RAM error flag, cleared only by reset
//   icount, dcount            completed access counters, wrap at 16 bits
module memory_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [31:0]       dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [31:0]       iload,
    output logic [31:0]       dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [31:0]       ramstore,
    input  logic [31:0]       ramload,
    input  logic [1:0]        ramstate,
    output logic              err,
    output logic [15:0]       icount,
    output logic [15:0]       dcount
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t        state;
    state_t        next;
    logic [SW-1:0] starve;
    logic [15:0]   icnt;
    logic [15:0]   dcnt;
    logic          err_q;

    logic dreq;
    logic starved;
    logic acc;
    logic rerr;
    logic iacc;
    logic dacc;

    assign dreq    = dREN | dWEN;
    assign starved = iREN && (starve == SMAX);
    assign acc     = (ramstate == RS_ACCESS);
    assign rerr    = (ramstate == RS_ERROR);
    assign iacc    = (state == IGRANT) && acc;
    assign dacc    = (state == DGRANT) && acc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // A grant is held until the RAM answers; an error wins over
    // everything, a completed access always returns through IDLE, and a
    // withdrawn request abandons the grant without completing it.
    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (dreq && !starved) begin
                    next = DGRANT;
                end else if (iREN) begin
                    next = IGRANT;
                end
            end
            IGRANT: begin
                if (rerr) begin
                    next = FAULT;
                end else if (acc) begin
                    next = IDLE;
                end else if (!iREN) begin
                    next = IDLE;
                end
            end
            DGRANT: begin
                if (rerr) begin
                    next = FAULT;
                end else if (acc) begin
                    next = IDLE;
                end else if (!dreq) begin
                    next = IDLE;
                end
            end
            FAULT: begin
                next = FAULT;
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    // RAM address and strobes depend only on state and requester inputs;
    // ramstate only reaches the requester-side wait/load signals.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = iREN;
        dwait    = dreq;
        iload    = '0;
        dload    = '0;
        unique case (state)
            IDLE: begin
                iwait = iREN;
                dwait = dreq;
            end
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iwait   = !acc;
                iload   = acc ? ramload : '0;
                dwait   = 1'b1;
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramWEN   = dWEN;
                // a write request overrides a simultaneous read
                ramREN   = dREN & ~dWEN;
                ramstore = dstore;
                dwait    = !acc;
                dload    = acc ? ramload : '0;
                iwait    = iREN;
            end
            FAULT: begin
                iwait = 1'b1;
                dwait = 1'b1;
            end
            default: begin
                iwait = 1'b1;
                dwait = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Error flag
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_q <= 1'b0;
        end else if ((state == IGRANT || state == DGRANT) && rerr) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

    // ------------------------------------------------------------------
    // Starvation counter
    // ------------------------------------------------------------------
    // Counts data accesses that completed while a fetch was waiting; once
    // it saturates, the next arbitration decision goes to the fetch.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve <= '0;
        end else if (iacc) begin
            starve <= '0;
        end else if (dacc && iREN && (starve != SMAX)) begin
            starve <= starve + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Access counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icnt <= '0;
        end else if (iacc) begin
            icnt <= icnt + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dcnt <= '0;
        end else if (dacc) begin
            dcnt <= dcnt + 16'd1;
        end
    end

    assign icount = icnt;
    assign dcount = dcnt;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameters: STARVE_MAX, default 4, max consecutive data grants while an instruction request waits; ADDR_W, default 32, address width.
REQ-002 SHALL have port: CLK  input  1  rising-edge clock.
REQ-003 SHALL have port: nRST  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: iREN  input  1  instruction fetch request; iaddr  input  ADDR_W  fetch address.
REQ-005 SHALL have ports: dREN, dWEN  input  1 each  data read/write request; daddr  input  ADDR_W; dstore  input  32  write data.
REQ-006 SHALL have ports: iwait, dwait  output  1 each  requester stall; iload, dload  output  32 each  read data.
REQ-007 SHALL have ports: ramREN, ramWEN  output  1 each; ramaddr  output  ADDR_W; ramstore  output  32; ramload  input  32; ramstate  input  2  (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
REQ-008 SHALL have ports: err  output  1  sticky RAM error flag; icount, dcount  output  16 each  completed-access counters.

Function
REQ-009 SHALL implement FSM states IDLE, IGRANT, DGRANT, FAULT.
REQ-010 IDLE: no RAM strobes; iwait = iREN, dwait = dREN | dWEN.
REQ-011 IDLE -> DGRANT when (dREN | dWEN) and not (iREN and starve counter == STARVE_MAX).
REQ-012 IDLE -> IGRANT when iREN and (no data request or starve counter == STARVE_MAX).
REQ-013 dREN and dWEN both high: write takes precedence, ramREN = 0.
REQ-014 IGRANT: ramREN = 1, ramaddr = iaddr; iload = ramload, iwait = 0 only in cycles where ramstate == ACCESS, else iwait = 1; dwait = 1.
REQ-015 DGRANT: ramaddr = daddr, ramWEN = dWEN, ramREN = dREN & ~dWEN, ramstore = dstore; dload = ramload, dwait = 0 only when ramstate == ACCESS; iwait = iREN.
REQ-016 In a grant state with ramstate == ACCESS, the next state SHALL be IDLE (one idle turnaround cycle, minimum 2 cycles per access); FREE/BUSY SHALL hold the grant.
REQ-017 Grant SHALL NOT switch mid-transaction; if the granted request drops before ACCESS, the FSM SHALL return to IDLE next cycle with no counter update.
REQ-018 ramstate == ERROR in any grant state -> FAULT next cycle; err set and held; both waits = 1; no RAM strobes.
REQ-019 FAULT SHALL be exited only by reset.
REQ-020 Starve counter (width clog2(STARVE_MAX+1)): +1 on each completed data access while iREN high, saturating at STARVE_MAX; cleared on each completed instruction access.
REQ-021 icount/dcount SHALL increment by 1 on each ACCESS cycle in IGRANT/DGRANT respectively, wrapping 0xFFFF -> 0x0000.
REQ-022 iload/dload SHALL be 0 whenever the corresponding wait is 1.
REQ-023 All RAM-side outputs SHALL be combinational from registered state plus requester inputs; no combinational path from ramstate to ramaddr.

Reset
REQ-024 nRST low SHALL asynchronously force state IDLE, err = 0, icount = dcount = 0, starve counter = 0.
REQ-025 During reset: ramREN = ramWEN = 0, iload = dload = 0, iwait/dwait per IDLE rule.
REQ-026 Reset asserted mid-grant SHALL abort the transaction; no counter increments.

Verification
REQ-027 Read priority: iREN = dREN = 1 from IDLE, starve = 0, RAM returns ACCESS on 2nd grant cycle -> DGRANT, ramaddr = daddr, dwait low 1 cycle, dcount = 1, iwait high throughout.
REQ-028 Starvation: iREN held and 5 back-to-back data reads with STARVE_MAX = 4 -> 4 data accesses complete, 5th grant goes to IGRANT, starve counter clears to 0.
REQ-029 Write: dWEN = 1, dREN = 1, daddr = 0x40, dstore = 0xDEADBEEF -> ramWEN = 1, ramREN = 0, ramstore = 0xDEADBEEF until ACCESS.
REQ-030 Error: ramstate = ERROR during IGRANT -> FAULT next cycle, err = 1, strobes low; requests ignored until nRST pulse restores IDLE, err = 0.
REQ-031 Reset mid-access: nRST low during DGRANT with ramstate = BUSY -> immediate IDLE, ramWEN = 0, dcount unchanged at 0.
REQ-032 Counter wrap: dcount preloaded via 65535 completed accesses plus one -> dcount = 0x0000.
